// File: rtl/i2c_slave_engine.sv
// i2c_slave_engine: byte-level I2C slave with filtered inputs, masked
// address match and syn/ack byte handshakes; SCL is never stretched.
// Ports:
//   clk, reset_n (async active-low)
//   scl, sda: raw bus inputs
//   sda_pd: 1 = pull SDA low
//   i2c_device_addr: last matched 7-bit address
//   rxd_syn/rxd_data/rxd_ack: write bytes to the consumer
//   txd_syn/txd_data/txd_ack: read bytes from the producer

module i2c_slave_engine #(
  parameter logic [6:0] ADDR_BASE   = 7'h0f,
  parameter logic [6:0] ADDR_MASK   = 7'h70,
  parameter int         FILTER_LEN  = 3,
  parameter int         HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_pd,
  output logic [6:0] i2c_device_addr,
  output logic       rxd_syn,
  output logic [7:0] rxd_data,
  input  logic       rxd_ack,
  input  logic       txd_syn,
  input  logic [7:0] txd_data,
  output logic       txd_ack
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HONE = HW'(1);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_LOAD,
    RD_DATA,
    RD_ACK,
    RD_DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [1:0]    scl_s;
  logic [1:0]    sda_s;
  logic          scl_f;
  logic          sda_f;
  logic          scl_q;
  logic          sda_q;
  logic [FW-1:0] scl_c;
  logic [FW-1:0] sda_c;
  logic [HW-1:0] hold_c;
  logic [7:0]    shift;
  logic [7:0]    tx_byte;
  logic [3:0]    bit_cnt;
  logic          ack_flag;
  logic          mst_ack;

  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;
  logic match;
  logic take;
  logic addr_hit;
  logic wr_done;
  logic drive;

  // Synchronizer plus stability filter; idle bus level is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
      scl_c <= '0;
      sda_c <= '0;
    end else begin
      scl_s <= {scl_s[0], scl};
      sda_s <= {sda_s[0], sda};
      scl_q <= scl_f;
      sda_q <= sda_f;
      if (scl_s[1] == scl_f) begin
        scl_c <= '0;
      end else if (scl_c == FMAX) begin
        scl_f <= scl_s[1];
        scl_c <= '0;
      end else begin
        scl_c <= scl_c + 1'b1;
      end
      if (sda_s[1] == sda_f) begin
        sda_c <= '0;
      end else if (sda_c == FMAX) begin
        sda_f <= sda_s[1];
        sda_c <= '0;
      end else begin
        sda_c <= sda_c + 1'b1;
      end
    end
  end

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start    = scl_f & scl_q & sda_q & ~sda_f;
  assign stop     = scl_f & scl_q & ~sda_q & sda_f;

  assign match = (shift[7:1] & ADDR_MASK) == (ADDR_BASE & ADDR_MASK);

  // A byte is accepted if nothing is pending or the pending
  // one is being acknowledged in this same cycle.
  assign take = ~rxd_syn | rxd_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    addr_hit = 1'b0;
    wr_done  = 1'b0;
    unique case (1'b1)
      start: state_n = ADDR;
      stop:  state_n = IDLE;
      default: begin
        unique case (state)
          IDLE: state_n = IDLE;
          ADDR: begin
            if (scl_fall && bit_cnt == 4'd8) begin
              addr_hit = match;
              state_n  = match ? ADDR_ACK : IDLE;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              state_n = shift[0] ? RD_LOAD : WR_DATA;
            end
          end
          WR_DATA: begin
            if (scl_fall && bit_cnt == 4'd8) begin
              wr_done = 1'b1;
              state_n = WR_ACK;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              state_n = WR_DATA;
            end
          end
          RD_LOAD: state_n = RD_DATA;
          RD_DATA: begin
            if (scl_fall && bit_cnt == 4'd7) begin
              state_n = RD_ACK;
            end
          end
          RD_ACK: begin
            if (scl_fall) begin
              state_n = mst_ack ? RD_LOAD : RD_DONE;
            end
          end
          RD_DONE: state_n = RD_DONE;
          default: state_n = IDLE;
        endcase
      end
    endcase
  end

  // Level the slave wants on SDA once the hold time has elapsed.
  always_comb begin
    drive = 1'b0;
    unique case (state)
      ADDR_ACK: drive = 1'b1;
      WR_ACK:   drive = ack_flag;
      RD_DATA:  drive = ~tx_byte[3'd7 - bit_cnt[2:0]];
      default:  drive = 1'b0;
    endcase
  end

  // Write and address bits are counted on SCL rise; read bits on
  // SCL fall, since that is when the next bit is put on the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt         <= '0;
      shift           <= '0;
      tx_byte         <= '0;
      ack_flag        <= 1'b0;
      mst_ack         <= 1'b0;
      i2c_device_addr <= '0;
      rxd_syn         <= 1'b0;
      rxd_data        <= '0;
      txd_ack         <= 1'b0;
    end else begin
      if (start || state_n != state) begin
        bit_cnt <= '0;
      end else if (scl_rise && (state == ADDR || state == WR_DATA)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end else if (scl_fall && state == RD_DATA) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (scl_rise && (state == ADDR || state == WR_DATA)) begin
        shift <= {shift[6:0], sda_f};
      end
      if (scl_rise && state == RD_ACK) begin
        mst_ack <= ~sda_f;
      end
      if (addr_hit) begin
        i2c_device_addr <= shift[7:1];
      end
      if (wr_done) begin
        ack_flag <= take;
        if (take) begin
          rxd_data <= shift;
        end
      end
      if (wr_done && take) begin
        rxd_syn <= 1'b1;
      end else if (rxd_ack) begin
        rxd_syn <= 1'b0;
      end
      txd_ack <= 1'b0;
      if (state == RD_LOAD) begin
        txd_ack <= txd_syn;
        tx_byte <= txd_syn ? txd_data : 8'hff;
      end
    end
  end

  // SDA only moves HOLD_CYCLES after a filtered SCL fall, except that
  // START/STOP release the bus at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_c <= '0;
      sda_pd <= 1'b0;
    end else if (start || stop) begin
      hold_c <= '0;
      sda_pd <= 1'b0;
    end else if (scl_fall) begin
      hold_c <= HMAX;
    end else if (hold_c != '0) begin
      hold_c <= hold_c - 1'b1;
      if (hold_c == HONE) begin
        sda_pd <= drive;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_engine.sv
// tb_i2c_slave_engine: bus-level master model driving i2c_slave_engine,
// with a consumer/producer model and expected results from I2C rules.

module tb_i2c_slave_engine;

  localparam logic [6:0] BASE = 7'h0f;
  localparam logic [6:0] MASK = 7'h70;
  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       g_scl = 1'b0;
  logic       g_sda = 1'b0;
  logic       rxd_ack = 1'b0;
  logic       txd_syn = 1'b0;
  logic [7:0] txd_data = 8'h00;
  logic       scl;
  logic       sda;
  logic       sda_pd;
  logic [6:0] i2c_device_addr;
  logic       rxd_syn;
  logic [7:0] rxd_data;
  logic       txd_ack;

  int checks = 0;
  int failures = 0;

  int   pd_cnt = 0;
  int   txa_cnt = 0;
  int   rxs_cnt = 0;
  logic rxs_q = 1'b0;

  logic       auto_ack = 1'b1;
  int         ack_wait = 0;
  logic [7:0] got_q[$];
  logic [6:0] last_addr = 7'h00;

  assign scl = scl_m ^ g_scl;
  assign sda = (sda_m & ~sda_pd) ^ g_sda;

  i2c_slave_engine dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .scl             (scl),
    .sda             (sda),
    .sda_pd          (sda_pd),
    .i2c_device_addr (i2c_device_addr),
    .rxd_syn         (rxd_syn),
    .rxd_data        (rxd_data),
    .rxd_ack         (rxd_ack),
    .txd_syn         (txd_syn),
    .txd_data        (txd_data),
    .txd_ack         (txd_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sda_pd) pd_cnt++;
    if (txd_ack) txa_cnt++;
    if (rxd_syn && !rxs_q) rxs_cnt++;
    rxs_q = rxd_syn;
  end

  // Consumer: acknowledges a presented byte three cycles later.
  always @(negedge clk) begin
    if (rxd_ack) begin
      rxd_ack = 1'b0;
      ack_wait = 0;
    end else if (auto_ack && rxd_syn) begin
      ack_wait++;
      if (ack_wait == 3) begin
        rxd_ack = 1'b1;
        got_q.push_back(rxd_data);
      end
    end else begin
      ack_wait = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic hits(input logic [6:0] a);
    return (a & MASK) == (BASE & MASK);
  endfunction

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start;
    sda_m = 1'b1;
    wq(Q);
    scl_m = 1'b1;
    wq(Q);
    sda_m = 1'b0;
    wq(Q);
    scl_m = 1'b0;
    wq(Q);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0;
    wq(Q);
    scl_m = 1'b1;
    wq(Q);
    sda_m = 1'b1;
    wq(Q);
  endtask

  task automatic bus_bit(input logic b, input logic glitch,
                         output logic seen);
    sda_m = b;
    wq(Q / 2);
    if (glitch) begin
      g_scl = 1'b1;
      wq(1);
      g_scl = 1'b0;
    end
    wq(Q / 2);
    scl_m = 1'b1;
    wq(Q / 2);
    seen = sda;
    if (glitch) begin
      g_sda = 1'b1;
      wq(1);
      g_sda = 1'b0;
    end
    wq(Q / 2);
    scl_m = 1'b0;
    wq(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic glitch,
                         output logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], glitch, s);
    bus_bit(1'b1, 1'b0, nack);
  endtask

  task automatic rd_byte(input logic mnack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, 1'b0, s);
      b[i] = s;
    end
    bus_bit(mnack, 1'b0, s);
  endtask

  task automatic wait_got(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 100) begin
      wq(1);
      t++;
    end
  endtask

  task automatic test_reset;
    wq(3);
    checks++;
    if (sda_pd !== 1'b0) begin
      failures++;
      $display("FAIL reset_sda_pd got=%0d exp=0", sda_pd);
    end
    checks++;
    if (i2c_device_addr !== 7'h00) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=00", i2c_device_addr);
    end
    checks++;
    if (rxd_syn !== 1'b0) begin
      failures++;
      $display("FAIL reset_rxd_syn got=%0d exp=0", rxd_syn);
    end
    checks++;
    if (rxd_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_rxd_data got=%h exp=00", rxd_data);
    end
    checks++;
    if (txd_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_txd_ack got=%0d exp=0", txd_ack);
    end
    reset_n = 1'b1;
    wq(10);
  endtask

  task automatic test_write_basic;
    logic n;
    got_q.delete();
    bus_start();
    wr_byte(8'h1e, 1'b0, n);
    checks++;
    if (n !== 1'b0) begin
      failures++;
      $display("FAIL wr_addr_ack got=%0d exp=0", n);
    end
    wr_byte(8'ha5, 1'b0, n);
    checks++;
    if (n !== 1'b0) begin
      failures++;
      $display("FAIL wr_data_ack got=%0d exp=0", n);
    end
    bus_stop();
    wait_got(1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'ha5) begin
      failures++;
      $display("FAIL wr_data n=%0d got=%h exp=a5", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    checks++;
    if (i2c_device_addr !== 7'h0f) begin
      failures++;
      $display("FAIL wr_dev_addr got=%h exp=0f", i2c_device_addr);
    end
    last_addr = 7'h0f;
  endtask

  task automatic test_addr_nack;
    logic n;
    int   p0;
    int   r0;
    p0 = pd_cnt;
    r0 = rxs_cnt;
    bus_start();
    wr_byte(8'ha0, 1'b0, n);
    checks++;
    if (n !== 1'b1) begin
      failures++;
      $display("FAIL nack_addr got=%0d exp=1", n);
    end
    wr_byte(8'h55, 1'b0, n);
    checks++;
    if (n !== 1'b1) begin
      failures++;
      $display("FAIL nack_data got=%0d exp=1", n);
    end
    bus_stop();
    checks++;
    if (pd_cnt != p0) begin
      failures++;
      $display("FAIL nack_pd cycles=%0d exp=0", pd_cnt - p0);
    end
    checks++;
    if (rxs_cnt != r0) begin
      failures++;
      $display("FAIL nack_rxd_syn got=%0d exp=0", rxs_cnt - r0);
    end
  endtask

  task automatic test_read_nack;
    logic       n;
    logic [7:0] b;
    int         t0;
    int         p1;
    txd_syn = 1'b1;
    txd_data = 8'h3c;
    t0 = txa_cnt;
    bus_start();
    wr_byte(8'h1f, 1'b0, n);
    checks++;
    if (n !== 1'b0) begin
      failures++;
      $display("FAIL rd_addr_ack got=%0d exp=0", n);
    end
    rd_byte(1'b1, b);
    checks++;
    if (b !== 8'h3c) begin
      failures++;
      $display("FAIL rd_byte got=%h exp=3c", b);
    end
    checks++;
    if (txa_cnt - t0 != 1) begin
      failures++;
      $display("FAIL rd_txd_ack got=%0d exp=1", txa_cnt - t0);
    end
    p1 = pd_cnt;
    rd_byte(1'b1, b);
    checks++;
    if (b !== 8'hff || pd_cnt != p1) begin
      failures++;
      $display("FAIL rd_done_bus got=%h pd=%0d exp=ff pd=0", b, pd_cnt - p1);
    end
    checks++;
    if (txa_cnt - t0 != 1) begin
      failures++;
      $display("FAIL rd_done_txd_ack got=%0d exp=1", txa_cnt - t0);
    end
    bus_stop();
    txd_syn = 1'b0;
  endtask

  task automatic test_overrun;
    logic n;
    auto_ack = 1'b0;
    got_q.delete();
    bus_start();
    wr_byte(8'h1e, 1'b0, n);
    wr_byte(8'h11, 1'b0, n);
    checks++;
    if (n !== 1'b0) begin
      failures++;
      $display("FAIL ovr_first_ack got=%0d exp=0", n);
    end
    wr_byte(8'h22, 1'b0, n);
    checks++;
    if (n !== 1'b1) begin
      failures++;
      $display("FAIL ovr_second_nack got=%0d exp=1", n);
    end
    bus_stop();
    checks++;
    if (rxd_syn !== 1'b1 || rxd_data !== 8'h11) begin
      failures++;
      $display("FAIL ovr_hold syn=%0d data=%h exp syn=1 data=11",
               rxd_syn, rxd_data);
    end
    auto_ack = 1'b1;
    wait_got(1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h11) begin
      failures++;
      $display("FAIL ovr_drain n=%0d exp=1 byte 11", got_q.size());
    end
  endtask

  task automatic test_glitch;
    logic       n;
    logic [7:0] d;
    d = 8'($urandom);
    got_q.delete();
    bus_start();
    wr_byte(8'h1e, 1'b1, n);
    checks++;
    if (n !== 1'b0) begin
      failures++;
      $display("FAIL glitch_addr_ack got=%0d exp=0", n);
    end
    wr_byte(d, 1'b1, n);
    checks++;
    if (n !== 1'b0) begin
      failures++;
      $display("FAIL glitch_data_ack got=%0d exp=0", n);
    end
    bus_stop();
    wait_got(1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== d) begin
      failures++;
      $display("FAIL glitch_data n=%0d exp byte %h", got_q.size(), d);
    end
  endtask

  task automatic test_restart;
    logic       n;
    logic       s;
    logic [7:0] d;
    int         r0;
    d = 8'($urandom);
    got_q.delete();
    r0 = rxs_cnt;
    bus_start();
    wr_byte(8'h1e, 1'b0, n);
    for (int i = 0; i < 4; i++) bus_bit(1'b1, 1'b0, s);
    bus_start();
    wr_byte(8'h1c, 1'b0, n);
    checks++;
    if (n !== 1'b0) begin
      failures++;
      $display("FAIL restart_addr_ack got=%0d exp=0", n);
    end
    wr_byte(d, 1'b0, n);
    bus_stop();
    wait_got(1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== d || rxs_cnt - r0 != 1) begin
      failures++;
      $display("FAIL restart_data n=%0d syn=%0d exp n=1 byte %h",
               got_q.size(), rxs_cnt - r0, d);
    end
    checks++;
    if (i2c_device_addr !== 7'h0e) begin
      failures++;
      $display("FAIL restart_dev_addr got=%h exp=0e", i2c_device_addr);
    end
    last_addr = 7'h0e;
  endtask

  task automatic test_reset_midread;
    logic n;
    int   t;
    txd_syn = 1'b1;
    txd_data = 8'h00;
    bus_start();
    wr_byte(8'h1f, 1'b0, n);
    t = 0;
    while (sda_pd !== 1'b1 && t < 40) begin
      wq(1);
      t++;
    end
    checks++;
    if (sda_pd !== 1'b1) begin
      failures++;
      $display("FAIL midread_drive got=%0d exp=1", sda_pd);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (sda_pd !== 1'b0 || i2c_device_addr !== 7'h00) begin
      failures++;
      $display("FAIL async_reset pd=%0d addr=%h exp pd=0 addr=00",
               sda_pd, i2c_device_addr);
    end
    last_addr = 7'h00;
    wq(3);
    reset_n = 1'b1;
    txd_syn = 1'b0;
    wq(5);
    bus_stop();
  endtask

  task automatic test_random_writes;
    logic       n;
    logic [6:0] a;
    logic [7:0] exp_q[$];
    int         nb;
    for (int f = 0; f < 6; f++) begin
      a = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 15))
                                      : 7'($urandom_range(0, 127));
      nb = $urandom_range(1, 3);
      exp_q.delete();
      got_q.delete();
      bus_start();
      wr_byte({a, 1'b0}, 1'b0, n);
      checks++;
      if (n !== !hits(a)) begin
        failures++;
        $display("FAIL rw_addr a=%h got=%0d exp=%0d", a, n, !hits(a));
      end
      if (hits(a)) begin
        last_addr = a;
        for (int k = 0; k < nb; k++) begin
          exp_q.push_back(8'($urandom));
          wr_byte(exp_q[k], 1'b0, n);
          checks++;
          if (n !== 1'b0) begin
            failures++;
            $display("FAIL rw_data_ack k=%0d got=%0d exp=0", k, n);
          end
        end
      end
      bus_stop();
      wait_got(exp_q.size());
      checks++;
      if (got_q != exp_q) begin
        failures++;
        $display("FAIL rw_bytes a=%h n=%0d exp n=%0d", a,
                 got_q.size(), exp_q.size());
      end
      checks++;
      if (i2c_device_addr !== last_addr) begin
        failures++;
        $display("FAIL rw_dev_addr got=%h exp=%h", i2c_device_addr,
                 last_addr);
      end
    end
  endtask

  task automatic test_random_reads;
    logic       n;
    logic [6:0] a;
    logic [7:0] b;
    logic [7:0] e;
    int         nb;
    int         t0;
    for (int f = 0; f < 5; f++) begin
      a = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 15))
                                      : 7'($urandom_range(0, 127));
      nb = $urandom_range(1, 3);
      txd_syn = 1'($urandom_range(0, 1));
      txd_data = 8'($urandom);
      e = (hits(a) && txd_syn) ? txd_data : 8'hff;
      t0 = txa_cnt;
      bus_start();
      wr_byte({a, 1'b1}, 1'b0, n);
      checks++;
      if (n !== !hits(a)) begin
        failures++;
        $display("FAIL rr_addr a=%h got=%0d exp=%0d", a, n, !hits(a));
      end
      if (hits(a)) last_addr = a;
      for (int k = 0; k < nb; k++) begin
        rd_byte(k == nb - 1, b);
        checks++;
        if (b !== e) begin
          failures++;
          $display("FAIL rr_byte a=%h k=%0d got=%h exp=%h", a, k, b, e);
        end
      end
      bus_stop();
      checks++;
      if (txa_cnt - t0 != ((hits(a) && txd_syn) ? nb : 0)) begin
        failures++;
        $display("FAIL rr_txd_ack got=%0d exp=%0d", txa_cnt - t0,
                 (hits(a) && txd_syn) ? nb : 0);
      end
      checks++;
      if (i2c_device_addr !== last_addr) begin
        failures++;
        $display("FAIL rr_dev_addr got=%h exp=%h", i2c_device_addr,
                 last_addr);
      end
    end
    txd_syn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_addr_nack();
    test_read_nack();
    test_overrun();
    test_glitch();
    test_restart();
    test_reset_midread();
    test_random_writes();
    test_random_reads();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
